// File: rtl/md_pkg.sv
// Shared MU op encodings, latency defaults and sequencer state encoding.
// The op-class helpers honour MD_SEQUENCER_MADD_EN (accumulate ops accepted only when defined).
package md_pkg;

    localparam logic [3:0] OP_NOP   = 4'b0000;
    localparam logic [3:0] OP_MULT  = 4'b0001;
    localparam logic [3:0] OP_MULTU = 4'b0010;
    localparam logic [3:0] OP_DIV   = 4'b0011;
    localparam logic [3:0] OP_DIVU  = 4'b0100;
    localparam logic [3:0] OP_MFHI  = 4'b0110;
    localparam logic [3:0] OP_MFLO  = 4'b0111;
    localparam logic [3:0] OP_MTHI  = 4'b1000;
    localparam logic [3:0] OP_MTLO  = 4'b1001;
    localparam logic [3:0] OP_MADD  = 4'b1010;
    localparam logic [3:0] OP_MADDU = 4'b1011;
    localparam logic [3:0] OP_MSUB  = 4'b1100;
    localparam logic [3:0] OP_MSUBU = 4'b1101;

    localparam int MULT_LAT_DEF = 5;
    localparam int DIV_LAT_DEF  = 10;
    localparam int CNT_W        = 5;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } md_state_e;

    function automatic logic is_mult_op(input logic [3:0] op);
        case (op)
            OP_MULT, OP_MULTU: is_mult_op = 1'b1;
`ifdef MD_SEQUENCER_MADD_EN
            OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: is_mult_op = 1'b1;
`endif
            default: is_mult_op = 1'b0;
        endcase
    endfunction

    function automatic logic is_div_op(input logic [3:0] op);
        is_div_op = (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/md_sequencer_if.sv
// E-stage controller <-> multiply/divide sequencer handshake and HI/LO read-back.
interface md_sequencer_if;
    logic        start;
    logic [3:0]  op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        req;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] rd_data;

    modport master (
        output start, op, src_a, src_b, req,
        input  busy, hi, lo, rd_data
    );

    modport slave (
        input  start, op, src_a, src_b, req,
        output busy, hi, lo, rd_data
    );
endinterface

// File: rtl/md_arith.sv
// Combinational HI/LO result datapath for mult/div/mthi/mtlo and, with
// MD_SEQUENCER_MADD_EN defined, the madd/msub accumulate ops.
module md_arith
    import md_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic [31:0] hi,
    input  logic [31:0] lo,
    output logic [31:0] next_hi,
    output logic [31:0] next_lo,
    output logic        div_zero
);

    logic signed [63:0] sa_ext;
    logic signed [63:0] sb_ext;
    logic signed [63:0] prod_s;
    logic        [63:0] prod_u;
    logic               div_ovf;
    logic        [31:0] divisor_u;
    logic signed [31:0] dividend_s;
    logic signed [31:0] divisor_s;
    logic signed [31:0] quot_s;
    logic signed [31:0] rem_s;
    logic        [31:0] quot_u;
    logic        [31:0] rem_u;

    assign sa_ext = {{32{src_a[31]}}, src_a};
    assign sb_ext = {{32{src_b[31]}}, src_b};
    assign prod_s = sa_ext * sb_ext;
    assign prod_u = {32'b0, src_a} * {32'b0, src_b};

    // A zero or overflowing divisor is replaced by 1 so the divider never traps;
    // for -2^31 / -1 that yields exactly the wrapped quotient and zero remainder.
    assign div_zero   = (src_b == 32'd0);
    assign div_ovf    = (src_a == 32'h8000_0000) && (src_b == 32'hFFFF_FFFF);
    assign divisor_u  = div_zero ? 32'd1 : src_b;
    assign dividend_s = signed'(src_a);
    assign divisor_s  = (div_zero || div_ovf) ? 32'sd1 : signed'(src_b);
    assign quot_s     = dividend_s / divisor_s;
    assign rem_s      = dividend_s % divisor_s;
    assign quot_u     = src_a / divisor_u;
    assign rem_u      = src_a % divisor_u;

`ifdef MD_SEQUENCER_MADD_EN
    logic [63:0] acc;
    assign acc = {hi, lo};
`endif

    always_comb begin
        next_hi = hi;
        next_lo = lo;
        case (op)
            OP_MULT:  {next_hi, next_lo} = $unsigned(prod_s);
            OP_MULTU: {next_hi, next_lo} = prod_u;
            OP_DIV: begin
                next_lo = $unsigned(quot_s);
                next_hi = $unsigned(rem_s);
            end
            OP_DIVU: begin
                next_lo = quot_u;
                next_hi = rem_u;
            end
            OP_MTHI:  next_hi = src_a;
            OP_MTLO:  next_lo = src_a;
`ifdef MD_SEQUENCER_MADD_EN
            OP_MADD:  {next_hi, next_lo} = acc + $unsigned(prod_s);
            OP_MADDU: {next_hi, next_lo} = acc + prod_u;
            OP_MSUB:  {next_hi, next_lo} = acc - $unsigned(prod_s);
            OP_MSUBU: {next_hi, next_lo} = acc - prod_u;
`endif
            default: ;
        endcase
    end

endmodule

// File: rtl/md_sequencer.sv
// E-stage multiply/divide sequencer: fixed-latency HI/LO commit with busy flag and CP0 flush.
// MD_SEQUENCER_MADD_EN enables the madd/maddu/msub/msubu encodings.
module md_sequencer
    import md_pkg::*;
#(
    parameter int MULT_LAT = MULT_LAT_DEF,
    parameter int DIV_LAT  = DIV_LAT_DEF
) (
    input  logic         clk,
    input  logic         reset,
    md_sequencer_if.slave mif
);

    md_state_e          state, state_nxt;
    logic [CNT_W-1:0]   count, count_nxt;
    logic [31:0]        hi_q, lo_q, hi_d, lo_d;
    logic [31:0]        pend_hi_p1, pend_lo_p1;
    logic               vld_p1, vld_nxt;
    logic               load_pend;
    logic               issue;
    logic [31:0]        next_hi, next_lo;
    logic               div_zero;

    md_arith u_arith (
        .op       (mif.op),
        .src_a    (mif.src_a),
        .src_b    (mif.src_b),
        .hi       (hi_q),
        .lo       (lo_q),
        .next_hi  (next_hi),
        .next_lo  (next_lo),
        .div_zero (div_zero)
    );

    // A flushed E-stage op (req) and any start while busy are simply not issued.
    assign issue = (state == ST_IDLE) && mif.start && !mif.req;

    always_comb begin
        state_nxt = state;
        count_nxt = count;
        vld_nxt   = vld_p1;
        load_pend = 1'b0;
        hi_d      = hi_q;
        lo_d      = lo_q;
        unique case (state)
            ST_IDLE: begin
                if (issue) begin
                    if (is_mult_op(mif.op)) begin
                        state_nxt = ST_RUN;
                        count_nxt = CNT_W'(MULT_LAT);
                        load_pend = 1'b1;
                        vld_nxt   = 1'b1;
                    end else if (is_div_op(mif.op)) begin
                        state_nxt = ST_RUN;
                        count_nxt = CNT_W'(DIV_LAT);
                        load_pend = 1'b1;
                        vld_nxt   = !div_zero;
                    end else if (mif.op == OP_MTHI) begin
                        hi_d = next_hi;
                    end else if (mif.op == OP_MTLO) begin
                        lo_d = next_lo;
                    end
                end
            end
            ST_RUN: begin
                if (count == CNT_W'(1)) begin
                    state_nxt = ST_IDLE;
                    vld_nxt   = 1'b0;
                    if (vld_p1) begin
                        hi_d = pend_hi_p1;
                        lo_d = pend_lo_p1;
                    end
                end else begin
                    count_nxt = count - CNT_W'(1);
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= ST_IDLE;
            count  <= '0;
            vld_p1 <= 1'b0;
            hi_q   <= '0;
            lo_q   <= '0;
        end else begin
            state  <= state_nxt;
            count  <= count_nxt;
            vld_p1 <= vld_nxt;
            hi_q   <= hi_d;
            lo_q   <= lo_d;
        end
    end

    // ---- issue -> commit stage: pending result captured at issue time
    always_ff @(posedge clk) begin
        if (load_pend) begin
            pend_hi_p1 <= next_hi;
            pend_lo_p1 <= next_lo;
        end
    end

    assign mif.busy    = (state == ST_RUN);
    assign mif.hi      = hi_q;
    assign mif.lo      = lo_q;
    assign mif.rd_data = (mif.op == OP_MFHI) ? hi_q :
                         (mif.op == OP_MFLO) ? lo_q : 32'd0;

endmodule

// File: tb/tb_md_sequencer.sv
// Scoreboard bench for md_sequencer: expected HI/LO queued at issue, checked at commit.
module tb_md_sequencer;
    import md_pkg::*;

    localparam int MULT_LAT = 5;
    localparam int DIV_LAT  = 10;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    md_sequencer_if mif();

    md_sequencer #(.MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT)) dut (
        .clk   (clk),
        .reset (reset),
        .mif   (mif)
    );

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        string       tag;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // The stall unit must never present start while busy.
    always @(negedge clk) begin
        if (!reset) check_eq("start_while_busy", 32'(mif.start & mif.busy), 32'd0);
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic rq);
        mif.start = 1'b1;
        mif.op    = op;
        mif.src_a = a;
        mif.src_b = b;
        mif.req   = rq;
        next_cycle();
        mif.start = 1'b0;
        mif.req   = 1'b0;
        mif.op    = OP_NOP;
    endtask

    task automatic expect_result(input int lat, input int req_cyc);
        exp_t e;
        if (sb.size() == 0) begin
            check_eq("sb_underflow", 32'(sb.size()), 32'd1);
            return;
        end
        e = sb.pop_front();
        for (int i = 1; i <= lat; i++) begin
            mif.req = (i == req_cyc);
            @(negedge clk);
            check_eq({e.tag, "_busy"}, 32'(mif.busy), 32'd1);
            next_cycle();
        end
        mif.req = 1'b0;
        @(negedge clk);
        check_eq({e.tag, "_done"}, 32'(mif.busy), 32'd0);
        check_eq({e.tag, "_hi"}, mif.hi, e.hi);
        check_eq({e.tag, "_lo"}, mif.lo, e.lo);
        next_cycle();
    endtask

    initial begin
        logic [31:0] a, b;
        logic [63:0] p;
        logic [3:0]  rop;

        mif.start = 1'b0;
        mif.op    = OP_MFHI;
        mif.src_a = '0;
        mif.src_b = '0;
        mif.req   = 1'b0;

        next_cycle();
        next_cycle();
        @(negedge clk);
        check_eq("rst_busy", 32'(mif.busy), 32'd0);
        check_eq("rst_hi", mif.hi, 32'd0);
        check_eq("rst_lo", mif.lo, 32'd0);
        check_eq("rst_rd", mif.rd_data, 32'd0);
        next_cycle();
        reset = 1'b0;
        mif.op = OP_NOP;
        next_cycle();

        sb.push_back('{32'hFFFF_FFFF, 32'hFFFF_FFFA, "mult"});
        drive(OP_MULT, 32'hFFFF_FFFE, 32'h0000_0003, 1'b0);
        expect_result(MULT_LAT, 0);

        sb.push_back('{32'd1, 32'd3, "divu"});
        drive(OP_DIVU, 32'd7, 32'd2, 1'b0);
        expect_result(DIV_LAT, 0);

        sb.push_back('{32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_neg"});
        drive(OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0);
        expect_result(DIV_LAT, 0);

        sb.push_back('{32'd0, 32'h8000_0000, "div_ovf"});
        drive(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        expect_result(DIV_LAT, 0);

        drive(OP_MTHI, 32'h11, 32'd0, 1'b0);
        @(negedge clk);
        check_eq("mthi_hi", mif.hi, 32'h11);
        check_eq("mthi_busy", 32'(mif.busy), 32'd0);
        next_cycle();
        drive(OP_MTLO, 32'h22, 32'd0, 1'b0);
        @(negedge clk);
        check_eq("mtlo_lo", mif.lo, 32'h22);
        next_cycle();

        sb.push_back('{32'h11, 32'h22, "div0"});
        drive(OP_DIV, 32'd5, 32'd0, 1'b0);
        expect_result(DIV_LAT, 0);

        drive(OP_MULT, 32'd7, 32'd9, 1'b1);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check_eq("flush_busy", 32'(mif.busy), 32'd0);
            check_eq("flush_hi", mif.hi, 32'h11);
            check_eq("flush_lo", mif.lo, 32'h22);
            next_cycle();
        end

        sb.push_back('{32'd0, 32'h0001_2340, "mult_req"});
        drive(OP_MULT, 32'h1234, 32'h10, 1'b0);
        expect_result(MULT_LAT, 3);

        drive(OP_MTHI, 32'hDEAD_BEEF, 32'd0, 1'b0);
        mif.start = 1'b1;
        mif.op    = OP_MFHI;
        @(negedge clk);
        check_eq("mfhi_rd", mif.rd_data, 32'hDEAD_BEEF);
        mif.op = OP_MFLO;
        #1;
        check_eq("mflo_rd", mif.rd_data, 32'h0001_2340);
        mif.start = 1'b0;
        mif.op    = OP_NOP;
        #1;
        check_eq("nop_rd", mif.rd_data, 32'd0);
        next_cycle();

        drive(OP_DIV, 32'd100, 32'd7, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("rstrun_busy", 32'(mif.busy), 32'd1);
            next_cycle();
        end
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
        @(negedge clk);
        check_eq("rstrun_busy0", 32'(mif.busy), 32'd0);
        check_eq("rstrun_hi", mif.hi, 32'd0);
        check_eq("rstrun_lo", mif.lo, 32'd0);
        next_cycle();

        drive(OP_MTHI, 32'd0, 32'd0, 1'b0);
        drive(OP_MTLO, 32'hFFFF_FFFF, 32'd0, 1'b0);
`ifdef MD_SEQUENCER_MADD_EN
        sb.push_back('{32'd1, 32'd5, "madd"});
        drive(OP_MADD, 32'd2, 32'd3, 1'b0);
        expect_result(MULT_LAT, 0);
        sb.push_back('{32'd1, 32'd4, "msub"});
        drive(OP_MSUB, 32'd1, 32'd1, 1'b0);
        expect_result(MULT_LAT, 0);
`else
        drive(OP_MADD, 32'd2, 32'd3, 1'b0);
        for (int i = 0; i <= MULT_LAT; i++) begin
            @(negedge clk);
            check_eq("madd_off_busy", 32'(mif.busy), 32'd0);
            check_eq("madd_off_hi", mif.hi, 32'd0);
            check_eq("madd_off_lo", mif.lo, 32'hFFFF_FFFF);
            next_cycle();
        end
`endif

        for (int k = 0; k < 6; k++) begin
            a = $urandom;
            b = $urandom | 32'd1;
            case (k % 3)
                0: begin
                    rop = OP_MULT;
                    p = longint'($signed(a)) * longint'($signed(b));
                    sb.push_back('{p[63:32], p[31:0], "rnd_mult"});
                end
                1: begin
                    rop = OP_MULTU;
                    p = {32'd0, a} * {32'd0, b};
                    sb.push_back('{p[63:32], p[31:0], "rnd_multu"});
                end
                default: begin
                    rop = OP_DIVU;
                    sb.push_back('{a % b, a / b, "rnd_divu"});
                end
            endcase
            drive(rop, a, b, 1'b0);
            expect_result((rop == OP_DIVU) ? DIV_LAT : MULT_LAT, 0);
        end

        check_eq("sb_drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/md_sequencer.md
# md_sequencer

Multiply/divide sequencer for the E stage of the five-stage MIPS pipeline. It accepts HI/LO-class operations from the E-stage controller, holds each multiply or divide for a fixed latency, and commits the result to HI/LO. It drives the busy flag consumed by the stall unit and honours the CP0 exception request so that flushed E-stage operations never alter HI/LO.

## Interface
- MULT_LAT, 5, busy cycles for mult/multu (and madd-class ops); legal range 1..31
- DIV_LAT, 10, busy cycles for div/divu; legal range 1..31
- clk  input  1  pipeline clock
- reset  input  1  synchronous, active-high reset
- start  input  1  E-stage instruction is a HI/LO-class op this cycle
- op  input  4  MU op: 0001 mult, 0010 multu, 0011 div, 0100 divu, 0110 mfhi, 0111 mflo, 1000 mthi, 1001 mtlo, 1010 madd, 1011 maddu, 1100 msub, 1101 msubu; others no-op
- src_a  input  32  forwarded rs operand
- src_b  input  32  forwarded rt operand
- req  input  1  CP0 exception/interrupt request; flushes the E-stage op
- busy  output  1  operation in flight
- hi  output  32  HI register
- lo  output  32  LO register
- rd_data  output  32  combinational: hi when op=0110, lo when op=0111, else 0

## Operation
- States: IDLE, RUN. Reset: IDLE, busy=0, hi=0, lo=0, count=0.
- IDLE, start=1, req=0:
  - mult-class op: latch the computed result into pending_hi/pending_lo, load count with MULT_LAT (madd-class also MULT_LAT), go to RUN.
  - div-class op, src_b≠0: latch the result, load DIV_LAT, go to RUN.
  - div-class op, src_b=0: go to RUN with the same latency; commit is suppressed and HI/LO stay unchanged.
  - mthi/mtlo: write src_a to hi/lo at this edge; no RUN.
- RUN: count decrements each cycle. When count reaches 1, commit the pending values to hi/lo, return to IDLE and deassert busy.
- Arithmetic:
  - mult/multu: {hi,lo} = signed/unsigned 64-bit product.
  - div/divu: lo = quotient truncated toward zero, hi = remainder with the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF signed gives lo=0x80000000, hi=0.
  - madd/msub: {hi,lo} ± product, modulo 2^64, using the HI/LO value at issue time.
- req=1 in the same cycle as start: the op is fully ignored, with no state, HI/LO or busy change.
- req=1 while in RUN: the in-flight op has already left E and is not flushed, so it completes normally.
- start while busy=1 (prevented by the stall unit): ignored, and the in-flight op is unaffected. The bench flags this as an assertion.
- mfhi/mflo: no state change.

## Timing
- Issue edge T (end of the start cycle): busy=1 from cycle T+1 through T+LAT. New hi/lo and busy=0 are visible in cycle T+LAT+1.
- mthi/mtlo: hi/lo are visible in the cycle after the start cycle; busy stays 0.
- rd_data is purely combinational from op/hi/lo, with zero latency.
- Reset during RUN: state is cleared at that edge, the pending result is discarded, and busy=0 the next cycle.

## Configuration
- MD_SEQUENCER_MADD_EN defined: ops 1010–1101 are accepted as described above.
- MD_SEQUENCER_MADD_EN undefined: those encodings are no-ops (no busy, no HI/LO change) and the accumulate datapath is not synthesised.

## Structure
- Shared package md_pkg holds:
  - the 4-bit MU op localparams (shared with the Control decoder and the stall unit)
  - the MULT_LAT/DIV_LAT defaults
  - the RUN/IDLE state encoding
- Sub-module md_arith is purely combinational. It takes op, src_a, src_b, hi, lo and produces next_hi, next_lo and div_zero. md_sequencer instantiates it once and owns the FSM, counter, pending registers and HI/LO.

## Test plan
- mult 0xFFFFFFFE × 0x00000003, start at cycle 0:
  - busy=1 in cycles 1–5.
  - Cycle 6: hi=0xFFFFFFFF, lo=0xFFFFFFFA, busy=0.
- divu 0x00000007 / 0x00000002:
  - busy for 10 cycles, then lo=3, hi=1.
  - div 0xFFFFFFF9 / 2 gives lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- div by zero with hi=0x11, lo=0x22:
  - busy for 10 cycles.
  - hi/lo remain 0x11/0x22.
- mult with req=1 in the start cycle:
  - busy stays 0 and hi/lo are unchanged.
  - req asserted in cycle 3 of a running mult does not abort it; the result commits on schedule.
- mthi 0xDEADBEEF then mfhi the next cycle: rd_data=0xDEADBEEF. Reset asserted mid-div: busy=0 and hi=lo=0 the next cycle.
- With MD_SEQUENCER_MADD_EN, madd 2×3 on hi=0, lo=0xFFFFFFFF: after 5 busy cycles, hi=1, lo=5. Without the macro, the same stimulus gives no busy and no change.
